// File: rtl/fp_mul_seq_pkg.sv
// Shared single-precision constants, FSM encoding and operand classification
// for the sequential multiplier and the IEEE-754 encoder that follows it.
package fp_mul_seq_pkg;

    localparam int          SP_EXP_BIAS = 127;
    localparam int          HP_EXP_BIAS = 15;
    localparam logic [22:0] QNAN_MANT   = 23'h40_0000;
    localparam logic [7:0]  EXP_MAX     = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MULT,
        NORM,
        ROUND,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_NAN,
        SPC_INF,
        SPC_ZERO
    } spc_t;

    // Special-case class of an operand pair, highest precedence first.
    // exp=0 counts as zero, so subnormals are flushed here.
    function automatic spc_t classify(input logic [31:0] a, input logic [31:0] b);
        logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        nan_a  = (a[30:23] == EXP_MAX) && (a[22:0] != 23'd0);
        nan_b  = (b[30:23] == EXP_MAX) && (b[22:0] != 23'd0);
        inf_a  = (a[30:23] == EXP_MAX) && (a[22:0] == 23'd0);
        inf_b  = (b[30:23] == EXP_MAX) && (b[22:0] == 23'd0);
        zero_a = (a[30:23] == 8'd0);
        zero_b = (b[30:23] == 8'd0);
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
            return SPC_NAN;
        else if (inf_a || inf_b)
            return SPC_INF;
        else if (zero_a || zero_b)
            return SPC_ZERO;
        else
            return SPC_NONE;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised significand {integer part, 23-bit fraction}.
module fp_round_rne (
    input  logic [24:0] sig,
    input  logic        guard,
    input  logic        sticky,
    output logic [22:0] frac,
    output logic        carry
);

    logic        round_up;
    logic [24:0] sum;

    assign round_up = guard & (sticky | sig[0]);
    assign sum      = sig + {24'd0, round_up};
    assign frac     = sum[22:0];
    // The integer part only leaves 2'b01 when rounding carries out of the fraction.
    assign carry    = (sum[24:23] != 2'b01);

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential single-precision multiplier: shift-add significand product, one
// multiplier bit per cycle, then normalise, round-to-nearest-even and pack.
module fp_mul_seq
    import fp_mul_seq_pkg::*;
#(
    parameter int MUL_CYCLES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [22:0] mant,
    output logic        flag_ovf,
    output logic        flag_unf,
    output logic        flag_inv
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    state_t             state_q, state_d;
    logic               unpack_ph;
    logic [31:0]        a_q, b_q;
    spc_t               spc_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [23:0]        mcand_q, mplier_q;
    logic [47:0]        prod_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [24:0]        psum;
    logic [22:0]        rnd_frac;
    logic               rnd_carry;
    logic signed [9:0]  exp_fin;

    // NOTE: every next-state signal gets its default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = UNPACK;
            UNPACK:  if (unpack_ph) state_d = (spc_q != SPC_NONE) ? DONE : MULT;
            MULT:    if (cnt_q == CNT_W'(MUL_CYCLES - 1)) state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    // Right-shifting accumulator: add the multiplicand into the upper half when
    // the current multiplier bit is set, then shift the whole product right.
    assign psum = {1'b0, prod_q[47:24]} + {1'b0, (mplier_q[0] ? mcand_q : 24'd0)};

    // After NORM the leading one always sits at bit 46.
    fp_round_rne u_round (
        .sig    (prod_q[47:23]),
        .guard  (prod_q[22]),
        .sticky (|prod_q[21:0]),
        .frac   (rnd_frac),
        .carry  (rnd_carry)
    );

    assign exp_fin = exp_q + $signed({9'd0, rnd_carry});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unpack_ph <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            spc_q     <= SPC_NONE;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            sign      <= 1'b0;
            exp       <= '0;
            mant      <= '0;
            flag_ovf  <= 1'b0;
            flag_unf  <= 1'b0;
            flag_inv  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_q       <= op_a;
                    b_q       <= op_b;
                    unpack_ph <= 1'b0;
                    flag_ovf  <= 1'b0;
                    flag_unf  <= 1'b0;
                    flag_inv  <= 1'b0;
                end
                UNPACK: if (!unpack_ph) begin
                    unpack_ph <= 1'b1;
                    spc_q     <= classify(a_q, b_q);
                    sign_q    <= a_q[31] ^ b_q[31];
                    exp_q     <= $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]})
                                 - 10'(SP_EXP_BIAS);
                    mcand_q   <= {1'b1, a_q[22:0]};
                    mplier_q  <= {1'b1, b_q[22:0]};
                    prod_q    <= '0;
                    cnt_q     <= '0;
                end else begin
                    case (spc_q)
                        SPC_NAN: begin
                            sign     <= 1'b0;
                            exp      <= EXP_MAX;
                            mant     <= QNAN_MANT;
                            flag_inv <= 1'b1;
                        end
                        SPC_INF: begin
                            sign <= sign_q;
                            exp  <= EXP_MAX;
                            mant <= '0;
                        end
                        SPC_ZERO: begin
                            sign <= sign_q;
                            exp  <= '0;
                            mant <= '0;
                        end
                        default: ;
                    endcase
                end
                MULT: begin
                    prod_q   <= {psum, prod_q[23:1]};
                    mplier_q <= {1'b0, mplier_q[23:1]};
                    cnt_q    <= cnt_q + 1'b1;
                end
                NORM: if (prod_q[47]) begin
                    // The bit shifted out is folded into bit 0, which stays inside sticky.
                    prod_q <= {1'b0, prod_q[47:2], prod_q[1] | prod_q[0]};
                    exp_q  <= exp_q + 10'sd1;
                end
                ROUND: begin
                    sign <= sign_q;
                    if (exp_fin >= 10'sd255) begin
                        exp      <= EXP_MAX;
                        mant     <= '0;
                        flag_ovf <= 1'b1;
                    end else if (exp_fin <= 10'sd0) begin
                        exp      <= '0;
                        mant     <= '0;
                        flag_unf <= 1'b1;
                    end else begin
                        exp  <= exp_fin[7:0];
                        mant <= rnd_frac;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: directed corner cases plus random operands
// against an exact-integer reference multiplier.
module tb_fp_mul_seq;

    localparam int MUL_CYCLES = 24;
    localparam int LAT_FULL   = MUL_CYCLES + 4;
    localparam int LAT_SPC    = 2;

    logic        clk, rst_n, start;
    logic [31:0] op_a, op_b;
    logic        busy, done, res_sign;
    logic [7:0]  res_exp;
    logic [22:0] res_mant;
    logic        flag_ovf, flag_unf, flag_inv;
    logic [31:0] res_word;
    logic [2:0]  res_flags;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] word;
        logic [2:0]  flags;   // {ovf, unf, inv}
        int          lat;
    } ref_t;

    fp_mul_seq #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .sign     (res_sign),
        .exp      (res_exp),
        .mant     (res_mant),
        .flag_ovf (flag_ovf),
        .flag_unf (flag_unf),
        .flag_inv (flag_inv)
    );

    assign res_word  = {res_sign, res_exp, res_mant};
    assign res_flags = {flag_ovf, flag_unf, flag_inv};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Exact product via 64-bit integers, rounded by comparing the discarded
    // remainder against half an ulp.
    function automatic ref_t ref_mul(input logic [31:0] a, input logic [31:0] b);
        ref_t r;
        int ea, eb, e, sh;
        longint unsigned ma, mb, p, q, rem, half;
        bit s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        nan_a  = (ea == 255) && (a[22:0] != 0);
        nan_b  = (eb == 255) && (b[22:0] != 0);
        inf_a  = (ea == 255) && (a[22:0] == 0);
        inf_b  = (eb == 255) && (b[22:0] == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        r.flags = 3'b000;
        r.lat   = LAT_SPC;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            r.word  = 32'h7FC0_0000;
            r.flags = 3'b001;
        end else if (inf_a || inf_b) begin
            r.word = {s, 8'hFF, 23'd0};
        end else if (zero_a || zero_b) begin
            r.word = {s, 31'd0};
        end else begin
            r.lat = LAT_FULL;
            ma = 64'(a[22:0]) | (64'd1 << 23);
            mb = 64'(b[22:0]) | (64'd1 << 23);
            p  = ma * mb;
            e  = ea + eb - 127;
            sh = 23;
            if (p >= (64'd1 << 47)) begin
                e++;
                sh = 24;
            end
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'd1 << 24)) begin
                e++;
                q = 64'd1 << 23;
            end
            if (e >= 255) begin
                r.word  = {s, 8'hFF, 23'd0};
                r.flags = 3'b100;
            end else if (e <= 0) begin
                r.word  = {s, 31'd0};
                r.flags = 3'b010;
            end else begin
                r.word = {s, 8'(e), q[22:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        int          sel;
        logic [7:0]  e;
        logic [22:0] m;
        sel = $urandom_range(0, 15);
        m   = 23'($urandom);
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom_range(1, 24));
            4, 5:    e = 8'($urandom_range(225, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        if (sel == 1 && $urandom_range(0, 1) == 1) m = 23'd0;
        if (sel == 6) m = 23'($urandom_range(0, 7)) << $urandom_range(0, 20);
        return {1'($urandom), e, m};
    endfunction

    // Called away from a clock edge; returns just after a falling edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit poke);
        ref_t r;
        int   n;
        r     = ref_mul(a, b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 0;
        check("busy_after_start", busy, 1'b1);
        check("flags_cleared", res_flags, 3'b000);
        @(posedge clk); #1;
        n    = 1;
        op_a = $urandom;
        op_b = $urandom;
        if (poke) start = 1'b1;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 3) start = 1'b0;
        end
        start = 1'b0;
        check("latency", n, r.lat);
        check("result", res_word, r.word);
        check("flags", res_flags, r.flags);
        @(posedge clk); #1;
        check("done_one_cycle", done, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("result_held", res_word, r.word);
        @(negedge clk);
    endtask

    logic [31:0] dir_a [14] = '{32'h3FC0_0000, 32'h7F80_0000, 32'h7F00_0000, 32'h0080_0000,
                                 32'h3F80_0001, 32'hBFC0_0000, 32'h7FC0_0000, 32'hFFC0_0001,
                                 32'hFF80_0000, 32'h8000_0000, 32'h0000_0001, 32'h3FC0_0000,
                                 32'h3FC0_0000, 32'h3FFF_FFFF};
    logic [31:0] dir_b [14] = '{32'h4000_0000, 32'h0000_0000, 32'h7F00_0000, 32'h0080_0000,
                                 32'h3F80_0001, 32'h3FC0_0000, 32'h3F80_0000, 32'hBF80_0000,
                                 32'h4000_0000, 32'h40A0_0000, 32'h3F80_0000, 32'h3F80_0001,
                                 32'h3F80_0003, 32'h3F80_0001};

    initial begin
        int   first_done, second_done, pulses;
        ref_t r;

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        #2;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_word", res_word, 32'd0);
        check("reset_flags", res_flags, 3'b000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(dir_a[0], dir_b[0], 1'b1);
        for (int i = 1; i < 14; i++) run_op(dir_a[i], dir_b[i], 1'b0);
        for (int i = 0; i < 50; i++) run_op(rand_op(), rand_op(), (i % 7) == 0);

        // Reset in the middle of a multiply.
        op_a  = 32'h3FC0_0000;
        op_b  = 32'h3FC0_0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 1'b0);
        check("midreset_done", done, 1'b0);
        check("midreset_word", res_word, 32'd0);
        check("midreset_flags", res_flags, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h3FC0_0000, 32'h4000_0000, 1'b0);

        // start held high across two operations.
        r           = ref_mul(32'h3FC0_0000, 32'h4000_0000);
        op_a        = 32'h3FC0_0000;
        op_b        = 32'h4000_0000;
        start       = 1'b1;
        first_done  = -1;
        second_done = -1;
        pulses      = 0;
        for (int k = 0; k < 90; k++) begin
            @(posedge clk); #1;
            if (k == 39) start = 1'b0;
            if (done) begin
                pulses++;
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
                check("held_result", res_word, r.word);
            end
        end
        check("held_pulses", pulses, 2);
        check("held_first_done", first_done, LAT_FULL);
        check("held_second_done", second_done, LAT_FULL + 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 Parameter MUL_CYCLES, default 24, shift-add iterations, one significand bit per cycle.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op_a, op_b  input  32 each  single-precision operands {sign, exp[7:0], mant[22:0]}.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse, result valid.
REQ-008 sign, exp, mant  output  1/8/23  product in internal single format; feeds the IEEE-754 encoder directly.
REQ-009 flag_ovf, flag_unf, flag_inv  output  1 each  overflow, underflow, invalid; valid with done, held until next start.

Function
REQ-010 FSM states SHALL be IDLE, UNPACK, MULT, NORM, ROUND and DONE.
REQ-011 Transitions:
  - IDLE->UNPACK when start=1.
  - UNPACK->DONE on a special case, else UNPACK->MULT.
  - MULT->NORM after MUL_CYCLES iterations.
  - NORM->ROUND->DONE->IDLE.
REQ-012 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-013 Operands SHALL be registered in UNPACK; op_a/op_b may change afterwards.
REQ-014 Inputs with exp=0 SHALL be treated as zero (subnormals flushed).
REQ-015 Special-case precedence in UNPACK, highest first:
  - NaN operand or inf*zero: result exp=FF, mant=0x400000, sign=0, flag_inv=1.
  - inf operand: exp=FF, mant=0.
  - zero operand: exp=0, mant=0.
REQ-016 Result sign SHALL be sign_a XOR sign_b for every non-NaN result.
REQ-017 MULT SHALL form the 48-bit product of {1,mant_a} x {1,mant_b} by shift-add; exponent sum = exp_a + exp_b - 127, held in a 10-bit signed register.
REQ-018 NORM: if product bit 47 is set, shift right 1 and add 1 to the exponent.
REQ-019 ROUND SHALL use round-to-nearest-even:
  - Guard is the bit below the 23-bit fraction; sticky is the OR of all bits below guard.
  - A fraction carry-out increments the exponent and clears mant.
REQ-020 Overflow: if the final biased exponent is >=255, output exp=FF, mant=0, flag_ovf=1.
REQ-021 Underflow: if the final biased exponent is <=0, output exp=0, mant=0, flag_unf=1 (flush, no subnormal).
REQ-022 Latency: with start sampled at edge 0, done SHALL be high in the cycle following edge MUL_CYCLES+4 (28 for the default).
REQ-023 Special-case latency: done SHALL be high in the cycle following edge 2.
REQ-024 Outputs and flags SHALL change only on entry to DONE and hold until the next DONE.
REQ-025 Flags SHALL be cleared when a new start is accepted.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, sign=0, exp=0, mant=0 and all flags 0, including mid-operation.
REQ-027 After rst_n deassertion, the first start SHALL be accepted on the first clock edge.

Structure
REQ-028 A shared package/include SHALL hold: SP_EXP_BIAS=127, HP_EXP_BIAS=15, QNAN_MANT=0x400000, EXP_MAX=8'hFF, and the FSM state encoding.
REQ-029 The encoder SHALL reuse the same package constants.
REQ-030 One sub-module, fp_round_rne, SHALL be natural; it is combinational, takes a 25-bit significand, guard and sticky, and returns the rounded fraction plus carry.
REQ-031 The MULT datapath and FSM SHALL remain in fp_mul_seq.

Verification
REQ-032 0x3FC00000 x 0x40000000 -> 0x40400000 (3.0), no flags, done in the cycle following edge 28.
REQ-033 0x7F800000 x 0x00000000 -> exp=FF, mant=0x400000, sign=0, flag_inv=1, done in the cycle following edge 2.
REQ-034 0x7F000000 x 0x7F000000 -> 0x7F800000, flag_ovf=1; 0x00800000 x 0x00800000 -> 0x00000000, flag_unf=1.
REQ-035 0x3F800001 x 0x3F800001 -> 0x3F800002 (sticky below half-ulp truncates); 0xBFC00000 x 0x3FC00000 -> 0xC0100000.
REQ-036 rst_n pulsed low at edge 10 of a MULT -> busy=0 and outputs 0 immediately; a following start gives a correct result in 28 cycles.
REQ-037 start held high for 40 cycles -> exactly one accepted operation per IDLE visit, with done pulses 30 cycles apart (28 cycles of latency plus the DONE and IDLE cycles).
